usr_sequencer: RTL

Command-driven controller for the 8-bit universal shift register. Mode encoding: 00 hold, 01 shift right (serial_in_left enters MSB), 10 shift left (serial_in_right enters LSB), 11 parallel load.
- Accepts one command at a time over a valid/ready handshake: load, shift by N, or rotate by N.
- Expands each command into the exact cycle-by-cycle mode/serial/parallel drive for the register.
- Observes register contents (reg_q) to close the rotate feedback loop.
- Sits between the host/test logic and the register's ui_in/uio_in drive.

---
 rtl/usr_pkg.sv | 34 +++
 rtl/usr_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared constants and types for the universal shift register sequencer
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHR  = 3'd2,
    OP_SHL  = 3'd3,
    OP_ROR  = 3'd4,
    OP_ROL  = 3'd5
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
  endfunction

  // Right-moving ops drive mode 01, left-moving ops drive mode 10.
  function automatic logic [1:0] shift_mode(input logic [2:0] op);
    return ((op == OP_SHR) || (op == OP_ROR)) ? MODE_SHR : MODE_SHL;
  endfunction

endpackage

// File: rtl/usr_sequencer.sv
// rtl/usr_sequencer.sv - expands load/shift/rotate commands into cycle-by-cycle register drive
module usr_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] reg_q,
  output logic [1:0]       mode,
  output logic             sil,
  output logic             sir,
  output logic [WIDTH-1:0] par_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fill_q, fill_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Outputs are computed from the next state so they line up with it on the same edge.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    mode_d  = MODE_HOLD;
    par_d   = par_q;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (cmd_valid) begin
          op_d   = cmd_op;
          cnt_d  = cmd_count;
          fill_d = cmd_fill;
          busy_d = 1'b1;
          if (cmd_op == OP_LOAD) begin
            state_d = ST_LOAD;
            mode_d  = MODE_LOAD;
            par_d   = cmd_data;
          end else if (is_shift_op(cmd_op) && (cmd_count != '0)) begin
            state_d = ST_SHIFT;
            mode_d  = shift_mode(cmd_op);
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          mode_d = shift_mode(op_q);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      mode_q  <= MODE_HOLD;
      par_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Rotates feed the bit leaving the register straight back in at the other end.
  always_comb begin
    sil = 1'b0;
    sir = 1'b0;
    if (state_q == ST_SHIFT) begin
      case (op_q)
        OP_SHR:  sil = fill_q;
        OP_SHL:  sir = fill_q;
        OP_ROR:  sil = reg_q[0];
        OP_ROL:  sir = reg_q[WIDTH-1];
        default: ;
      endcase
    end
  end

  logic unused_reg_bits;
  assign unused_reg_bits = ^reg_q[WIDTH-2:1];

  assign cmd_ready = (state_q == ST_IDLE);
  assign mode      = mode_q;
  assign par_out   = par_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
